// File: rtl/mgmt_gpio_sequencer.sv
// Management GPIO pad owner: software-driven value or a hardware blink sequencer
// with programmable on/off periods and blink count, configured through a small register port.
module mgmt_gpio_sequencer #(
    parameter int TICK_W = 24,
    parameter int CNT_W  = 8
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] blinks_done,
    output logic             gpio_out_pad,
    output logic             gpio_outenb_pad,
    output logic             gpio_inenb_pad
);
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;

    // Counter load value for a period register; a period of 0 behaves as 1.
    function automatic logic [TICK_W-1:0] eff_load(input logic [TICK_W-1:0] v);
        return (v == '0) ? '0 : v - TICK_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state, state_nxt;
    logic               mode, sw_value, oe;
    logic [TICK_W-1:0]  on_ticks, off_ticks;
    logic [CNT_W-1:0]   count;
    logic [TICK_W-1:0]  on_snap, off_snap, tick;
    logic [CNT_W-1:0]   cnt_snap;

    logic               ctrl_wr, mode_nxt, sw_nxt, oe_nxt;
    logic               stop, launch, tick_zero, last_blink;
    logic               pad_nxt, busy_nxt, done_nxt;
    logic [CNT_W-1:0]   blinks_nxt;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:TICK_W];

    // Register values as they will be after this edge, so CTRL writes reach the pad next cycle.
    assign ctrl_wr  = cfg_we && (cfg_addr == 2'd0);
    assign mode_nxt = ctrl_wr ? cfg_wdata[0] : mode;
    assign sw_nxt   = ctrl_wr ? cfg_wdata[1] : sw_value;
    assign oe_nxt   = ctrl_wr ? cfg_wdata[2] : oe;

    assign stop       = (state != IDLE) && (abort || (ctrl_wr && !cfg_wdata[0]));
    assign launch     = (state == IDLE) && start && !abort && mode && (count != '0);
    assign tick_zero  = (tick == '0);
    assign last_blink = (({1'b0, blinks_done} + (CNT_W+1)'(1)) == {1'b0, cnt_snap});

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            mode      <= 1'b0;
            sw_value  <= 1'b0;
            oe        <= 1'b0;
            on_ticks  <= '0;
            off_ticks <= '0;
            count     <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    {oe, sw_value, mode} <= cfg_wdata[2:0];
                2'd1:    on_ticks  <= cfg_wdata[TICK_W-1:0];
                2'd2:    off_ticks <= cfg_wdata[TICK_W-1:0];
                default: count     <= cfg_wdata[CNT_W-1:0];
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = ON;
            ON: begin
                if (stop)           state_nxt = IDLE;
                else if (tick_zero) state_nxt = OFF;
            end
            OFF: begin
                if (stop)           state_nxt = IDLE;
                else if (tick_zero) state_nxt = last_blink ? IDLE : ON;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state == OFF) && !stop && tick_zero && last_blink;
        pad_nxt    = 1'b0;
        blinks_nxt = blinks_done;
        if (state_nxt == ON)        pad_nxt = 1'b1;
        else if (state_nxt == IDLE) pad_nxt = mode_nxt ? 1'b0 : sw_nxt;
        if (launch)
            blinks_nxt = '0;
        else if ((state == OFF) && !stop && tick_zero)
            blinks_nxt = sat_inc(blinks_done);
    end

    // Working copies only matter while busy, so they carry no reset.
    always_ff @(posedge core_clk) begin
        if (launch) begin
            on_snap  <= on_ticks;
            off_snap <= off_ticks;
            cnt_snap <= count;
            tick     <= eff_load(on_ticks);
        end else if ((state == ON) && tick_zero) begin
            tick <= eff_load(off_snap);
        end else if ((state == OFF) && tick_zero) begin
            tick <= eff_load(on_snap);
        end else begin
            tick <= tick - TICK_W'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            blinks_done     <= '0;
            gpio_out_pad    <= 1'b0;
            gpio_outenb_pad <= 1'b1;
            gpio_inenb_pad  <= 1'b0;
        end else begin
            busy            <= busy_nxt;
            done            <= done_nxt;
            blinks_done     <= blinks_nxt;
            gpio_out_pad    <= pad_nxt;
            gpio_outenb_pad <= ~oe_nxt;
            gpio_inenb_pad  <= oe_nxt;
        end
    end
endmodule

// File: tb/tb_mgmt_gpio_sequencer.sv
// Self-checking bench for mgmt_gpio_sequencer: directed scenarios plus randomized
// blink runs compared against an expected pad waveform built from the blink rules.
module tb_mgmt_gpio_sequencer;
    localparam int TICK_W = 24;
    localparam int CNT_W  = 8;

    logic             core_clk = 1'b0;
    logic             core_rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_addr = 2'd0;
    logic [31:0]      cfg_wdata = 32'd0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad;
    logic [CNT_W-1:0] blinks_done;

    int checks = 0;
    int failures = 0;

    mgmt_gpio_sequencer #(.TICK_W(TICK_W), .CNT_W(CNT_W)) dut (
        .core_clk(core_clk), .core_rst(core_rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .abort(abort), .busy(busy), .done(done),
        .blinks_done(blinks_done), .gpio_out_pad(gpio_out_pad),
        .gpio_outenb_pad(gpio_outenb_pad), .gpio_inenb_pad(gpio_inenb_pad)
    );

    always #5 core_clk = ~core_clk;

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad, busy, done} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_outputs got pad/oenb/ienb/busy/done=%b want 01000",
                     {gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad, busy, done});
        end
        checks++;
        if (blinks_done !== 8'd0) begin
            failures++;
            $display("FAIL reset_blinks got %0d want 0", blinks_done);
        end
        core_rst = 1'b0;
        step();
    endtask

    task automatic test_sw_mode();
        cfg_write(2'd0, 32'b110);
        checks++;
        if ({gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad} !== 3'b101) begin
            failures++;
            $display("FAIL sw_high got pad/oenb/ienb=%b want 101",
                     {gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad});
        end
        cfg_write(2'd0, 32'b100);
        checks++;
        if ({gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad} !== 3'b001) begin
            failures++;
            $display("FAIL sw_low got pad/oenb/ienb=%b want 001",
                     {gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad});
        end
    endtask

    // One blink run. abort_at / busy_start_at are run-relative cycle indices (-1 = never).
    task automatic test_sequence(input int on, input int off, input int cnt,
                                 input int abort_at, input int busy_start_at);
        int eon, eoff, period, total;
        bit exp_pad[$];
        eon = (on == 0) ? 1 : on;
        eoff = (off == 0) ? 1 : off;
        period = eon + eoff;
        total = cnt * period;
        exp_pad.delete();
        for (int b = 0; b < cnt; b++) begin
            repeat (eon) exp_pad.push_back(1'b1);
            repeat (eoff) exp_pad.push_back(1'b0);
        end
        cfg_write(2'd1, on);
        cfg_write(2'd2, off);
        cfg_write(2'd3, cnt);
        cfg_write(2'd0, 32'b101);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < total; j++) begin
            checks++;
            if (gpio_out_pad !== exp_pad[j] || busy !== 1'b1 || done !== 1'b0 ||
                blinks_done !== CNT_W'(j / period)) begin
                failures++;
                $display("FAIL run_cycle on=%0d off=%0d cnt=%0d j=%0d got pad=%b busy=%b done=%b blinks=%0d want pad=%b busy=1 done=0 blinks=%0d",
                         on, off, cnt, j, gpio_out_pad, busy, done, blinks_done, exp_pad[j], j / period);
            end
            if (j == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (gpio_out_pad !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                        blinks_done !== CNT_W'(j / period)) begin
                        failures++;
                        $display("FAIL abort k=%0d got pad=%b busy=%b done=%b blinks=%0d want 0 0 0 %0d",
                                 k, gpio_out_pad, busy, done, blinks_done, j / period);
                    end
                    step();
                end
                return;
            end
            start = (j == busy_start_at);
            step();
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || gpio_out_pad !== 1'b0 || blinks_done !== CNT_W'(cnt)) begin
            failures++;
            $display("FAIL run_end got done=%b busy=%b pad=%b blinks=%0d want 1 0 0 %0d",
                     done, busy, gpio_out_pad, blinks_done, cnt);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || blinks_done !== CNT_W'(cnt)) begin
            failures++;
            $display("FAIL done_pulse_width got done=%b busy=%b blinks=%0d want 0 0 %0d",
                     done, busy, blinks_done, cnt);
        end
    endtask

    task automatic test_count_zero();
        cfg_write(2'd1, 3);
        cfg_write(2'd3, 0);
        cfg_write(2'd0, 32'b101);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || gpio_out_pad !== 1'b0) begin
                failures++;
                $display("FAIL count_zero k=%0d got busy=%b done=%b pad=%b want 0 0 0",
                         k, busy, done, gpio_out_pad);
            end
            step();
        end
    endtask

    task automatic test_start_abort_idle();
        cfg_write(2'd3, 2);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || gpio_out_pad !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle got busy=%b pad=%b want 0 0", busy, gpio_out_pad);
        end
    endtask

    task automatic test_ctrl_abort();
        cfg_write(2'd1, 5);
        cfg_write(2'd2, 5);
        cfg_write(2'd3, 3);
        cfg_write(2'd0, 32'b001);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        cfg_write(2'd0, 32'b110);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || gpio_out_pad !== 1'b1 || gpio_outenb_pad !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_abort got busy=%b done=%b pad=%b oenb=%b want 0 0 1 0",
                     busy, done, gpio_out_pad, gpio_outenb_pad);
        end
    endtask

    task automatic test_reset_midrun();
        cfg_write(2'd1, 3);
        cfg_write(2'd2, 5);
        cfg_write(2'd3, 2);
        cfg_write(2'd0, 32'b101);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        checks++;
        if (busy !== 1'b1 || gpio_out_pad !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_off got busy=%b pad=%b want 1 0", busy, gpio_out_pad);
        end
        core_rst = 1'b1;
        step();
        core_rst = 1'b0;
        checks++;
        if ({gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad, busy, done} !== 5'b01000 ||
            blinks_done !== 8'd0) begin
            failures++;
            $display("FAIL reset_midrun got pad/oenb/ienb/busy/done=%b blinks=%0d want 01000 0",
                     {gpio_out_pad, gpio_outenb_pad, gpio_inenb_pad, busy, done}, blinks_done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || gpio_out_pad !== 1'b0) begin
            failures++;
            $display("FAIL start_after_reset got busy=%b pad=%b want 0 0", busy, gpio_out_pad);
        end
        // COUNT must have been cleared: sequencer mode alone cannot launch a run.
        cfg_write(2'd0, 32'b001);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL count_cleared got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 8; r++) begin
            int on, off, cnt, total, ab, bs;
            on = $urandom_range(0, 5);
            off = $urandom_range(0, 5);
            cnt = $urandom_range(1, 4);
            total = cnt * (((on == 0) ? 1 : on) + ((off == 0) ? 1 : off));
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(0, total - 1) : -1;
            bs = $urandom_range(0, total - 1);
            test_sequence(on, off, cnt, ab, bs);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sw_mode();
        test_sequence(4, 2, 3, -1, -1);
        test_sequence(0, 0, 2, -1, -1);
        test_count_zero();
        test_sequence(10, 10, 5, 25, 5);
        test_start_abort_idle();
        test_ctrl_abort();
        test_random_runs();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
